// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: optional dirty-victim writeback, then line burst fill.
// Latency: 1 + LINE_WORDS (+ LINE_WORDS if dirty) + 1 stalled cycles at zero wait; beats wait on mem_ack_i.
module dcache_refill_ctrl #(
   parameter int WIDTH      = 32,
   parameter int LINE_WORDS = 4,
   localparam int IDXW      = $clog2(LINE_WORDS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             miss_i,
   input  logic             dirty_i,
   input  logic [WIDTH-1:0] miss_addr_i,
   input  logic [WIDTH-1:0] victim_addr_i,
   input  logic [WIDTH-1:0] victim_rdata_i,
   output logic [IDXW-1:0]  victim_idx_o,
   output logic             fill_we_o,
   output logic [IDXW-1:0]  fill_idx_o,
   output logic [WIDTH-1:0] fill_data_o,
   output logic             fill_done_o,
   output logic             stall_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   input  logic             mem_ack_i,
   input  logic [WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   localparam logic [WIDTH-1:0] LINE_MASK = ~WIDTH'(LINE_WORDS * 4 - 1);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] fill_base_q, fill_base_d;
   logic [WIDTH-1:0] wb_base_q, wb_base_d;
   logic             last_beat;
   logic [WIDTH-1:0] beat_off;

   assign last_beat = (cnt_q == IDXW'(LINE_WORDS - 1));
   assign beat_off  = WIDTH'({cnt_q, 2'b00});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         fill_base_q <= '0;
         wb_base_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_base_q <= fill_base_d;
         wb_base_q   <= wb_base_d;
      end
   end

   // Counter wraps to zero on the last beat because LINE_WORDS is a power of two.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_base_d = fill_base_q;
      wb_base_d   = wb_base_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (miss_i) begin
               fill_base_d = miss_addr_i & LINE_MASK;
               wb_base_d   = victim_addr_i & LINE_MASK;
               state_d     = dirty_i ? WB : FILL;
            end
         end
         WB: begin
            if (mem_ack_i) begin
               cnt_d = cnt_q + IDXW'(1);
               if (last_beat) state_d = FILL;
            end
         end
         FILL: begin
            if (mem_ack_i) begin
               cnt_d = cnt_q + IDXW'(1);
               if (last_beat) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      victim_idx_o = '0;
      fill_we_o    = 1'b0;
      fill_idx_o   = '0;
      fill_data_o  = '0;
      fill_done_o  = 1'b0;
      stall_o      = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      case (state_q)
         IDLE: stall_o = miss_i;
         WB: begin
            stall_o      = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = 1'b1;
            mem_addr_o   = wb_base_q + beat_off;
            mem_wdata_o  = victim_rdata_i;
            victim_idx_o = cnt_q;
         end
         FILL: begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = fill_base_q + beat_off;
            fill_idx_o = cnt_q;
            if (mem_ack_i) begin
               fill_we_o   = 1'b1;
               fill_data_o = mem_rdata_i;
            end
         end
         DONE: begin
            stall_o     = 1'b1;
            fill_done_o = 1'b1;
         end
         default: stall_o = 1'b0;
      endcase
   end

endmodule
